snake_input_queue: RTL
======================

SNAKE_INPUT_QUEUE -- requirements
Module: snake_input_queue

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable clock cycles required to accept a button level change (10 ms at 25 MHz).
REQ-002 Parameter CNT_BIT, default 18, is the debounce counter width; it SHALL satisfy 2^CNT_BIT > DEBOUNCE_CYCLES.
REQ-003 Parameter DEPTH, default 4, is the turn queue depth and SHALL be a power of two of at least 2.
REQ-004 Parameter PTR_BIT, default 2, is log2(DEPTH).
REQ-005 Port clock_25, input, 1 bit: the single 25 MHz clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port right_P, input, 1 bit: raw asynchronous right button, active high.
REQ-008 Port left_P, input, 1 bit: raw asynchronous left button, active high.
REQ-009 Port game_tik, input, 1 bit: one-cycle game-step strobe from the game timer.
REQ-010 Port turn_valid, output, 1 bit: registered one-cycle pulse marking a turn command delivered to the snake FSM.
REQ-011 Port turn_dir, output, 1 bit: registered direction qualified by turn_valid; 1 = right, 0 = left.
REQ-012 Port queue_count, output, PTR_BIT+1 bits: number of queued commands, ranging 0..DEPTH.
REQ-013 Port overflow, output, 1 bit: registered one-cycle pulse indicating that a press was dropped.
REQ-014 Port conflict, output, 1 bit: registered one-cycle pulse indicating that simultaneous presses were discarded.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-016 Each button SHALL keep a debounced level "stable" and a counter that clears whenever the synchronized value equals stable and otherwise increments.
REQ-017 When the counter equals DEBOUNCE_CYCLES-1 and the synchronized value still differs from stable, stable SHALL toggle and the counter SHALL clear in the same edge.
REQ-018 A press event SHALL occur for exactly one cycle on each 0->1 transition of stable; releases SHALL produce no event.
REQ-019 A raw level held constant from the first sampling edge SHALL be enqueued on clock edge DEBOUNCE_CYCLES+3, counting that first sampling edge as edge 1.
REQ-020 Bounce of any length shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-021 Right and left press events in the same cycle SHALL both be discarded, with conflict pulsed on the next edge.
REQ-022 A single press event SHALL push its direction at the tail of a DEPTH-entry FIFO.
REQ-023 A push while full with no pop SHALL be dropped, with overflow pulsed on the next edge and queue contents unchanged.
REQ-024 A game_tik while queue_count > 0 SHALL pop the head; on the next edge turn_valid=1 and turn_dir=head.
REQ-025 A game_tik while empty SHALL produce turn_valid=0.
REQ-026 Pop eligibility SHALL use the pre-edge count, so a push in the same cycle as game_tik on an empty queue is not delivered until a later game_tik.
REQ-027 A simultaneous push and pop while full SHALL accept the push, leave queue_count = DEPTH and drop nothing.
REQ-028 A simultaneous push and pop at any other non-empty count SHALL leave queue_count unchanged.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 The block SHALL NOT suppress reversal commands; it delivers direction requests only, and the snake FSM decides their meaning.

Reset
REQ-031 Reset SHALL clear synchronizers, stable levels, counters, pointers, queue_count, turn_valid, turn_dir, overflow and conflict to 0.
REQ-032 Reset SHALL take priority over game_tik and press events in the same cycle.
REQ-033 Reset asserted mid-debounce or with a non-empty queue SHALL discard all pending state, with no output pulse on the following edge.
REQ-034 A button held through reset deassertion SHALL register as a new press after a full debounce.

Verification (DEBOUNCE_CYCLES=4, DEPTH=4)
REQ-035 Scenario: right_P held high -> queue_count goes 0->1 at edge 7; next game_tik -> turn_valid=1, turn_dir=1 for one cycle; queue_count=0.
REQ-036 Scenario: left_P toggled every 2 cycles for 40 cycles then held low -> no push and queue_count stays 0.
REQ-037 Scenario: five separate debounced right presses with no game_tik -> queue_count=4 and exactly one overflow pulse; four game_tiks then deliver four turn_dir=1 pulses.
REQ-038 Scenario: right_P and left_P rise on the same edge and are held -> one conflict pulse and queue_count=0.
REQ-039 Scenario: a push coincides with game_tik on an empty queue -> turn_valid=0 on that step and the command is delivered on the following game_tik.
REQ-040 Scenario: reset for one cycle with queue_count=3 -> all outputs 0 on the next edge; subsequent game_tik yields turn_valid=0.

Source files
------------

// File: rtl/snake_input_queue.sv
// snake_input_queue: debounces the left/right buttons and queues turn commands for the snake FSM.
// Latency: a clean press is enqueued DEBOUNCE_CYCLES+3 edges after the raw level first changes.
//          A queued command is delivered one edge after the game_tik that pops it.
// Backpressure: none upstream. A press arriving while the queue is full with no pop is dropped
//               and flagged on overflow. Presses on both buttons in the same cycle are dropped
//               and flagged on conflict.
// Ports:
//   clock_25, reset    : 25 MHz clock and synchronous active-high reset
//   right_P, left_P    : raw asynchronous buttons, active high
//   game_tik           : one-cycle game-step strobe; pops the head of the queue when it is non-empty
//   turn_valid/turn_dir: registered delivery pulse; turn_dir is 1 for right, 0 for left
//   queue_count        : number of queued commands, 0..DEPTH
//   overflow, conflict : registered one-cycle drop indications
module snake_input_queue #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_BIT         = 18,
  parameter int DEPTH           = 4,
  parameter int PTR_BIT         = 2
) (
  input  logic               clock_25,
  input  logic               reset,
  input  logic               right_P,
  input  logic               left_P,
  input  logic               game_tik,
  output logic               turn_valid,
  output logic               turn_dir,
  output logic [PTR_BIT:0]   queue_count,
  output logic               overflow,
  output logic               conflict
);

  localparam logic [CNT_BIT-1:0] DB_LAST  = CNT_BIT'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_BIT:0]   FULL_CNT = (PTR_BIT+1)'(DEPTH);

  // Button vectors are indexed [1] = right, [0] = left.
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         stable_q, stable_d;
  logic [1:0]         stable_prev_q;
  logic [CNT_BIT-1:0] cnt_q [2];
  logic [CNT_BIT-1:0] cnt_d [2];
  logic [1:0]         press;

  logic [DEPTH-1:0]   fifo_q;
  logic [PTR_BIT-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_BIT:0]   count_q, count_d;
  logic               turn_valid_q, turn_dir_q, overflow_q, conflict_q;

  logic               push, push_dir, push_ok, pop, full;

  // Debounce: the counter only runs while the synchronized level disagrees with
  // the accepted level, so any return to agreement restarts the stability window.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      stable_d[b] = stable_q[b];
      cnt_d[b]    = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == DB_LAST) begin
          stable_d[b] = ~stable_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // One-cycle press on each rising edge of the accepted level; releases are ignored.
  assign press    = stable_q & ~stable_prev_q;
  assign push     = press[1] ^ press[0];
  assign push_dir = press[1];

  // Pop eligibility uses the pre-edge count, so a same-cycle push onto an empty
  // queue waits for a later game_tik.
  assign full     = (count_q == FULL_CNT);
  assign pop      = game_tik && (count_q != '0);
  // When full, a simultaneous pop frees the head slot; the write lands in that
  // slot while the read still returns its old contents.
  assign push_ok  = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '{default: '0};
      fifo_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      turn_valid_q  <= 1'b0;
      turn_dir_q    <= 1'b0;
      overflow_q    <= 1'b0;
      conflict_q    <= 1'b0;
    end else begin
      sync1_q       <= {right_P, left_P};
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= push_dir;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q       <= count_d;
      turn_valid_q  <= pop;
      turn_dir_q    <= pop & fifo_q[rd_ptr_q];
      overflow_q    <= push & full & ~pop;
      conflict_q    <= press[1] & press[0];
    end
  end

  assign turn_valid  = turn_valid_q;
  assign turn_dir    = turn_dir_q;
  assign queue_count = count_q;
  assign overflow    = overflow_q;
  assign conflict    = conflict_q;

endmodule
